// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: FSM state encoding and ALU op codes.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b100;
  localparam logic [2:0] OP_SHL     = 3'b101;
  localparam logic [2:0] OP_SHR     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  function automatic logic isLegalOp(input logic [2:0] op);
    return op != OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw button plus a one-cycle rising-edge pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic press
);

  logic syncA;
  logic syncB;
  logic prevB;

  // Flops reset to 1 so a button already held at reset release looks like "no edge".
  always_ff @(posedge clk) begin
    if (rst) begin
      syncA <= 1'b1;
      syncB <= 1'b1;
      prevB <= 1'b1;
    end else begin
      syncA <= btnRaw;
      syncB <= syncA;
      prevB <= syncB;
    end
  end

  assign press = syncB & ~prevB;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and op code from one switch bus on successive button presses,
// holds them for the external ALU and captures its result/flags in one EXEC cycle.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         load_btn,
  input  logic [N-1:0] alu_result,
  input  logic         alu_cout,
  input  logic         alu_neg,
  input  logic         alu_zero,
  output logic [N-1:0] a_q,
  output logic [N-1:0] b_q,
  output logic [2:0]   sel_q,
  output logic [N-1:0] result_q,
  output logic         cout_q,
  output logic         neg_q,
  output logic         zero_q,
  output logic         done,
  output logic         err,
  output logic [2:0]   state_o
);

  state_t state;
  state_t stateNext;
  logic   press;
  logic   loadA;
  logic   loadB;
  logic   loadOp;
  logic   opBad;
  logic   capture;

  btn_edge_sync uBtn (
    .clk    (clk),
    .rst    (rst),
    .btnRaw (load_btn),
    .press  (press)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadA     = 1'b0;
    loadB     = 1'b0;
    loadOp    = 1'b0;
    opBad     = 1'b0;
    capture   = 1'b0;
    case (state)
      LOAD_A: if (press) begin
        loadA     = 1'b1;
        stateNext = LOAD_B;
      end
      LOAD_B: if (press) begin
        loadB     = 1'b1;
        stateNext = LOAD_OP;
      end
      LOAD_OP: if (press) begin
        if (isLegalOp(data_in[2:0])) begin
          loadOp    = 1'b1;
          stateNext = EXEC;
        end else begin
          opBad = 1'b1;
        end
      end
      // Single-cycle state: presses arriving here are deliberately dropped.
      EXEC: begin
        capture   = 1'b1;
        stateNext = SHOW;
      end
      SHOW: if (press) stateNext = LOAD_A;
      default: stateNext = LOAD_A;
    endcase
  end

  // Reset clears the data registers too, so the LEDs show zeros and EXEC capture is cancelled.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (loadA) a_q <= data_in;
      if (loadB) b_q <= data_in;
      if (loadOp) begin
        sel_q <= data_in[2:0];
        err   <= 1'b0;
      end
      if (opBad) err <= 1'b1;
      if (capture) begin
        result_q <= alu_result;
        cout_q   <= alu_cout;
        neg_q    <= alu_neg;
        zero_q   <= alu_zero;
      end
    end
  end

  assign done    = (state == SHOW);
  assign state_o = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small behavioural ALU attached.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dataIn;
  logic       loadBtn;
  logic [3:0] aluResult;
  logic       aluCout;
  logic       aluNeg;
  logic       aluZero;
  logic [3:0] aQ;
  logic [3:0] bQ;
  logic [2:0] selQ;
  logic [3:0] resultQ;
  logic       coutQ;
  logic       negQ;
  logic       zeroQ;
  logic       done;
  logic       err;
  logic [2:0] stateO;

  int testCnt = 0;
  int failCnt = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (dataIn),
    .load_btn   (loadBtn),
    .alu_result (aluResult),
    .alu_cout   (aluCout),
    .alu_neg    (aluNeg),
    .alu_zero   (aluZero),
    .a_q        (aQ),
    .b_q        (bQ),
    .sel_q      (selQ),
    .result_q   (resultQ),
    .cout_q     (coutQ),
    .neg_q      (negQ),
    .zero_q     (zeroQ),
    .done       (done),
    .err        (err),
    .state_o    (stateO)
  );

  // Behavioural ALU beside the sequencer; carry is the bit shifted/carried out.
  always_comb begin
    logic [4:0] wide;
    wide = 5'd0;
    case (selQ)
      3'b000: wide = {1'b0, aQ} + {1'b0, bQ};
      3'b001: wide = {1'b0, aQ} + {1'b0, ~bQ} + 5'd1;
      3'b010: wide = {1'b0, aQ & bQ};
      3'b011: wide = {1'b0, aQ | bQ};
      3'b100: wide = {1'b0, aQ ^ bQ};
      3'b101: wide = {aQ, 1'b0};
      3'b110: wide = {aQ[0], 1'b0, aQ[3:1]};
      default: wide = 5'd0;
    endcase
    aluResult = wide[3:0];
    aluCout   = wide[4];
    aluNeg    = wide[3];
    aluZero   = (wide[3:0] == 4'd0);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testCnt++;
    assert (obs === exp)
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press with value v; returns at the falling edge just after the load edge, button released.
  task automatic pressBtn(input logic [3:0] v);
    repeat (2) @(negedge clk);
    dataIn  = v;
    loadBtn = 1'b1;
    repeat (3) @(negedge clk);
    loadBtn = 1'b0;
  endtask

  task automatic chkZeroOutputs(input string tag);
    chk({tag, "_state"}, {5'd0, stateO}, 8'd0);
    chk({tag, "_a"}, {4'd0, aQ}, 8'd0);
    chk({tag, "_b"}, {4'd0, bQ}, 8'd0);
    chk({tag, "_sel"}, {5'd0, selQ}, 8'd0);
    chk({tag, "_res"}, {4'd0, resultQ}, 8'd0);
    chk({tag, "_flags"}, {5'd0, coutQ, negQ, zeroQ}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd0);
    chk({tag, "_err"}, {7'd0, err}, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    loadBtn = 1'b0;
    dataIn  = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chkZeroOutputs("reset");

    // Add 0101 + 0011
    pressBtn(4'b0101);
    chk("t1_stateB", {5'd0, stateO}, 8'd1);
    chk("t1_a", {4'd0, aQ}, 8'h05);
    pressBtn(4'b0011);
    chk("t1_stateOp", {5'd0, stateO}, 8'd2);
    chk("t1_b", {4'd0, bQ}, 8'h03);
    pressBtn(4'b0000);
    chk("t1_exec", {5'd0, stateO}, 8'd3);
    chk("t1_execDone", {7'd0, done}, 8'd0);
    @(negedge clk);
    chk("t1_show", {5'd0, stateO}, 8'd4);
    chk("t1_done", {7'd0, done}, 8'd1);
    chk("t1_res", {4'd0, resultQ}, 8'b1000);
    chk("t1_flags", {5'd0, coutQ, negQ, zeroQ}, 8'b010);
    chk("t1_sel", {5'd0, selQ}, 8'd0);
    chk("t1_ab", {aQ, bQ}, 8'h53);

    // Shift left 1001
    pressBtn(4'b1111);
    chk("t2_back", {5'd0, stateO}, 8'd0);
    chk("t2_backDone", {7'd0, done}, 8'd0);
    chk("t2_keepRes", {4'd0, resultQ}, 8'b1000);
    pressBtn(4'b1001);
    pressBtn(4'b0000);
    pressBtn(4'b0101);
    chk("t2_exec", {5'd0, stateO}, 8'd3);
    @(negedge clk);
    chk("t2_res", {4'd0, resultQ}, 8'b0010);
    chk("t2_flags", {5'd0, coutQ, negQ, zeroQ}, 8'b100);
    chk("t2_done", {7'd0, done}, 8'd1);

    // Illegal op then AND
    pressBtn(4'b0000);
    pressBtn(4'b1100);
    pressBtn(4'b1010);
    pressBtn(4'b0111);
    chk("t3_illState", {5'd0, stateO}, 8'd2);
    chk("t3_illErr", {7'd0, err}, 8'd1);
    chk("t3_illSel", {5'd0, selQ}, 8'd5);
    @(negedge clk);
    chk("t3_illStay", {5'd0, stateO}, 8'd2);
    pressBtn(4'b0010);
    chk("t3_exec", {5'd0, stateO}, 8'd3);
    chk("t3_errClr", {7'd0, err}, 8'd0);
    @(negedge clk);
    chk("t3_res", {4'd0, resultQ}, 8'b1000);
    chk("t3_flags", {5'd0, coutQ, negQ, zeroQ}, 8'b010);
    chk("t3_sel", {5'd0, selQ}, 8'd2);

    // Long hold in LOAD_A: one load only, three edges after the first high sample
    pressBtn(4'b0000);
    chk("t4_start", {5'd0, stateO}, 8'd0);
    repeat (2) @(negedge clk);
    dataIn  = 4'b0110;
    loadBtn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i < 3) begin
        chk("t4_wait", {5'd0, stateO}, 8'd0);
      end else begin
        chk("t4_state", {5'd0, stateO}, 8'd1);
        chk("t4_a", {4'd0, aQ}, 8'h06);
        dataIn = 4'b1111;
      end
    end
    loadBtn = 1'b0;

    // Reset while in EXEC (xor would otherwise be captured)
    pressBtn(4'b0011);
    repeat (2) @(negedge clk);
    dataIn  = 4'b0100;
    loadBtn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_exec", {5'd0, stateO}, 8'd3);
    rst     = 1'b1;
    loadBtn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chkZeroOutputs("t5_rst");
    @(negedge clk);
    chk("t5_noCapRes", {4'd0, resultQ}, 8'd0);
    chk("t5_noCapDone", {7'd0, done}, 8'd0);
    chk("t5_idle", {5'd0, stateO}, 8'd0);

    // Button held through reset
    dataIn  = 4'b0111;
    loadBtn = 1'b1;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_heldState", {5'd0, stateO}, 8'd0);
    chk("t6_heldA", {4'd0, aQ}, 8'd0);
    loadBtn = 1'b0;
    pressBtn(4'b0111);
    chk("t6_load", {5'd0, stateO}, 8'd1);
    chk("t6_a", {4'd0, aQ}, 8'h07);
    pressBtn(4'b0111);
    pressBtn(4'b0000);
    @(negedge clk);
    chk("t6_res", {4'd0, resultQ}, 8'b1110);
    chk("t6_done", {7'd0, done}, 8'd1);
    pressBtn(4'b0011);
    chk("t6_ret", {5'd0, stateO}, 8'd0);
    chk("t6_retDone", {7'd0, done}, 8'd0);
    chk("t6_retRes", {4'd0, resultQ}, 8'b1110);
    chk("t6_retA", {4'd0, aQ}, 8'h07);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
